// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// Define ILLEGAL_OP_TRAP_EN to trap on undefined opcodes; otherwise they retire as NOPs.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_sel,
  output logic [1:0] alu_a_sel,
  output logic       alu_b_sel,
  output logic [1:0] wb_sel,
  output logic       reg_write,
  output logic       trap
);

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_TARGET = 2'b01;
  localparam logic [1:0] PC_JALR   = 2'b10;

  localparam logic [1:0] A_OLD_PC = 2'b01;

  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_IMM  = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
`ifdef ILLEGAL_OP_TRAP_EN
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
`else
    S_WB     = 3'd4
`endif
  } state_e;

  state_e state_q, state_d;

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_sel    = 2'b00;
    alu_a_sel = 2'b00;
    alu_b_sel = 1'b0;
    wb_sel    = 2'b00;
    reg_write = 1'b0;
    trap      = 1'b0;

    // Outputs are forced quiet during reset; the register forces FETCH on its own.
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            pc_sel   = PC_PLUS4;
            state_d  = S_DECODE;
          end
        end
        S_DECODE: state_d = S_EXEC;
        S_EXEC: begin
          case (opcode)
            OPC_OP:     state_d = S_WB;
            OPC_OP_IMM: begin
              alu_b_sel = 1'b1;
              state_d   = S_WB;
            end
            OPC_LOAD, OPC_STORE: begin
              alu_b_sel = 1'b1;
              state_d   = S_MEM;
            end
            OPC_LUI:    state_d = S_WB;
            OPC_AUIPC: begin
              alu_a_sel = A_OLD_PC;
              alu_b_sel = 1'b1;
              state_d   = S_WB;
            end
            OPC_JAL: begin
              pc_sel   = PC_TARGET;
              pc_write = 1'b1;
              state_d  = S_WB;
            end
            OPC_JALR: begin
              alu_b_sel = 1'b1;
              pc_sel    = PC_JALR;
              pc_write  = 1'b1;
              state_d   = S_WB;
            end
            OPC_BRANCH: begin
              pc_sel   = PC_TARGET;
              pc_write = branch_taken;
              state_d  = S_FETCH;
            end
            OPC_MISC_MEM, OPC_SYSTEM: state_d = S_FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
            default: state_d = S_TRAP;
`else
            default: state_d = S_FETCH;
`endif
          endcase
        end
        S_MEM: begin
          // Address operands stay selected for the whole memory wait.
          mem_req   = 1'b1;
          mem_we    = (opcode == OPC_STORE);
          alu_b_sel = 1'b1;
          if (mem_ready) state_d = (opcode == OPC_LOAD) ? S_WB : S_FETCH;
        end
        S_WB: begin
          reg_write = 1'b1;
          case (opcode)
            OPC_LOAD:          wb_sel = WB_LOAD;
            OPC_JAL, OPC_JALR: wb_sel = WB_PC4;
            OPC_LUI:           wb_sel = WB_IMM;
            default:           wb_sel = 2'b00;
          endcase
          state_d = S_FETCH;
        end
`ifdef ILLEGAL_OP_TRAP_EN
        S_TRAP: trap = 1'b1;
`endif
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a per-cycle vector trace plus timed instruction sequences.
// Expectations for undefined opcodes follow ILLEGAL_OP_TRAP_EN.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'b0110011;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b1;
  logic       mem_req, mem_we, ir_write, pc_write, alu_b_sel, reg_write, trap;
  logic [1:0] pc_sel, alu_a_sel, wb_sel;

  multicycle_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_sel       (pc_sel),
    .alu_a_sel    (alu_a_sel),
    .alu_b_sel    (alu_b_sel),
    .wb_sel       (wb_sel),
    .reg_write    (reg_write),
    .trap         (trap)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011, LUI = 7'b0110111, AUIPC = 7'b0010111;
  localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111, BR = 7'b1100011;
  localparam logic [6:0] SYS = 7'b1110011, ILL = 7'b1111111;

  // Packed order: mem_req mem_we ir_write pc_write pc_sel a_sel b_sel wb_sel reg_write trap
  function automatic logic [12:0] o(input logic mr, mw, irw, pcw, input logic [1:0] pcs, as,
                                    input logic bs, input logic [1:0] wb, input logic rw, tr);
    return {mr, mw, irw, pcw, pcs, as, bs, wb, rw, tr};
  endfunction

  localparam logic [12:0] ZERO    = o(0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0);
  localparam logic [12:0] F_WAIT  = o(1, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0);
  localparam logic [12:0] F_RDY   = o(1, 0, 1, 1, 2'b00, 2'b00, 0, 2'b00, 0, 0);
  localparam logic [12:0] EX_IMM  = o(0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 0, 0);
  localparam logic [12:0] EX_AUI  = o(0, 0, 0, 0, 2'b00, 2'b01, 1, 2'b00, 0, 0);
  localparam logic [12:0] EX_JAL  = o(0, 0, 0, 1, 2'b01, 2'b00, 0, 2'b00, 0, 0);
  localparam logic [12:0] EX_JALR = o(0, 0, 0, 1, 2'b10, 2'b00, 1, 2'b00, 0, 0);
  localparam logic [12:0] EX_BR_T = o(0, 0, 0, 1, 2'b01, 2'b00, 0, 2'b00, 0, 0);
  localparam logic [12:0] EX_BR_N = o(0, 0, 0, 0, 2'b01, 2'b00, 0, 2'b00, 0, 0);
  localparam logic [12:0] MEM_LD  = o(1, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 0, 0);
  localparam logic [12:0] MEM_ST  = o(1, 1, 0, 0, 2'b00, 2'b00, 1, 2'b00, 0, 0);
  localparam logic [12:0] WB_ALU  = o(0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 1, 0);
  localparam logic [12:0] WB_LD   = o(0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b01, 1, 0);
  localparam logic [12:0] WB_PC   = o(0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b10, 1, 0);
  localparam logic [12:0] WB_IMM  = o(0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b11, 1, 0);
  localparam logic [12:0] TRAP_O  = o(0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 1);

  typedef struct {
    logic        rst;
    logic [6:0]  opcode;
    logic        taken;
    logic        ready;
    logic [12:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [6:0] op, input logic bt, input logic rdy,
                     input logic [12:0] exp, input string name);
    vec_t v;
    v.rst = r; v.opcode = op; v.taken = bt; v.ready = rdy; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  // Drives mem_ready like a memory with a fixed wait count per request and times one instruction.
  task automatic measure(input logic [6:0] op, input int waits, input int exp_gap,
                         input logic [1:0] exp_wb, input int exp_req, input string nm);
    int cyc = 0, ir_cyc = -1, req = 0, wcnt = 0;
    bit done = 0;
    rst = 1'b0; opcode = op; branch_taken = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk); #1;
      if (mem_req) begin
        mem_ready = (wcnt == waits);
        wcnt = mem_ready ? 0 : wcnt + 1;
        req++;
      end else begin
        mem_ready = 1'b0;
      end
      #1;
      if (ir_write) ir_cyc = cyc;
      if (reg_write) begin
        done = 1;
        check({nm, " ir->wb gap"}, cyc - ir_cyc, exp_gap);
        check({nm, " wb_sel"}, {30'd0, wb_sel}, {30'd0, exp_wb});
        check({nm, " mem_req cycles"}, req, exp_req);
      end
      cyc++;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL %s timeout: no reg_write within 40 cycles, expected one", nm);
    end
    @(negedge clk); mem_ready = 1'b0; #1;
    check({nm, " back in FETCH"}, {30'd0, mem_req, reg_write}, 32'd2);
  endtask

  initial begin
    // Reset, then OP with no memory waits.
    add(1, OP, 0, 1, ZERO,   "reset c0");
    add(1, OP, 0, 1, ZERO,   "reset c1");
    add(0, OP, 0, 1, F_RDY,  "op fetch");
    add(0, OP, 0, 1, ZERO,   "op decode");
    add(0, OP, 0, 1, ZERO,   "op exec");
    add(0, OP, 0, 1, WB_ALU, "op wb");
    add(0, OPI, 0, 1, F_RDY,  "opimm fetch");
    add(0, OPI, 0, 1, ZERO,   "opimm decode");
    add(0, OPI, 0, 1, EX_IMM, "opimm exec");
    add(0, OPI, 0, 1, WB_ALU, "opimm wb");
    // LOAD with two MEM wait cycles: 7 cycles total.
    add(0, LD, 0, 1, F_RDY,  "load fetch");
    add(0, LD, 0, 1, ZERO,   "load decode");
    add(0, LD, 0, 0, EX_IMM, "load exec");
    add(0, LD, 0, 0, MEM_LD, "load mem w1");
    add(0, LD, 0, 0, MEM_LD, "load mem w2");
    add(0, LD, 0, 1, MEM_LD, "load mem rdy");
    add(0, LD, 0, 0, WB_LD,  "load wb");
    // STORE with one FETCH wait.
    add(0, ST, 0, 0, F_WAIT, "store fetch wait");
    add(0, ST, 0, 1, F_RDY,  "store fetch");
    add(0, ST, 0, 1, ZERO,   "store decode");
    add(0, ST, 0, 1, EX_IMM, "store exec");
    add(0, ST, 0, 1, MEM_ST, "store mem");
    // Branch taken / not taken, both return straight to FETCH.
    add(0, BR, 1, 1, F_RDY,   "br_t fetch");
    add(0, BR, 1, 1, ZERO,    "br_t decode");
    add(0, BR, 1, 1, EX_BR_T, "br_t exec");
    add(0, BR, 0, 1, F_RDY,   "br_n fetch");
    add(0, BR, 0, 1, ZERO,    "br_n decode");
    add(0, BR, 0, 1, EX_BR_N, "br_n exec");
    // Jumps, LUI, AUIPC, SYSTEM.
    add(0, JALR, 0, 1, F_RDY,   "jalr fetch");
    add(0, JALR, 0, 1, ZERO,    "jalr decode");
    add(0, JALR, 0, 1, EX_JALR, "jalr exec");
    add(0, JALR, 0, 1, WB_PC,   "jalr wb");
    add(0, JAL, 0, 1, F_RDY,  "jal fetch");
    add(0, JAL, 0, 1, ZERO,   "jal decode");
    add(0, JAL, 0, 1, EX_JAL, "jal exec");
    add(0, JAL, 0, 1, WB_PC,  "jal wb");
    add(0, LUI, 0, 1, F_RDY,  "lui fetch");
    add(0, LUI, 0, 1, ZERO,   "lui decode");
    add(0, LUI, 0, 1, ZERO,   "lui exec");
    add(0, LUI, 0, 1, WB_IMM, "lui wb");
    add(0, AUIPC, 0, 1, F_RDY,  "auipc fetch");
    add(0, AUIPC, 0, 1, ZERO,   "auipc decode");
    add(0, AUIPC, 0, 1, EX_AUI, "auipc exec");
    add(0, AUIPC, 0, 1, WB_ALU, "auipc wb");
    add(0, SYS, 0, 1, F_RDY, "sys fetch");
    add(0, SYS, 0, 1, ZERO,  "sys decode");
    add(0, SYS, 0, 1, ZERO,  "sys exec");
    // Reset during a STORE's MEM wait abandons it without a write.
    add(0, ST, 0, 1, F_RDY,  "st_rst fetch");
    add(0, ST, 0, 1, ZERO,   "st_rst decode");
    add(0, ST, 0, 0, EX_IMM, "st_rst exec");
    add(0, ST, 0, 0, MEM_ST, "st_rst mem wait");
    add(1, ST, 0, 0, ZERO,   "st_rst reset cycle");
    add(0, OP, 0, 0, F_WAIT, "st_rst refetch wait");
    add(0, OP, 0, 1, F_RDY,  "st_rst refetch");
    add(0, OP, 0, 1, ZERO,   "st_rst decode2");
    add(0, OP, 0, 1, ZERO,   "st_rst exec2");
    // Reset landing on the WB cycle suppresses reg_write.
    add(1, OP, 0, 1, ZERO,   "wb_rst reset cycle");
    add(0, OP, 0, 0, F_WAIT, "wb_rst refetch wait");
    // Undefined opcode.
    add(0, ILL, 0, 1, F_RDY, "ill fetch");
    add(0, ILL, 0, 1, ZERO,  "ill decode");
    add(0, ILL, 0, 0, ZERO,  "ill exec");
`ifdef ILLEGAL_OP_TRAP_EN
    add(0, ILL, 0, 0, TRAP_O, "ill trap c1");
    add(0, ILL, 0, 1, TRAP_O, "ill trap c2");
`else
    add(0, ILL, 0, 0, F_WAIT, "ill nop fetch c1");
    add(0, ILL, 0, 0, F_WAIT, "ill nop fetch c2");
`endif
    add(1, OP, 0, 0, ZERO,   "ill reset");
    add(0, OP, 0, 0, F_WAIT, "ill after reset");

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; opcode = vecs[i].opcode;
      branch_taken = vecs[i].taken; mem_ready = vecs[i].ready;
      #1;
      check(vecs[i].name,
            {19'd0, mem_req, mem_we, ir_write, pc_write, pc_sel, alu_a_sel, alu_b_sel,
             wb_sel, reg_write, trap},
            {19'd0, vecs[i].exp});
    end

    // Timed sequences, starting from the FETCH left by the trace.
    measure(OP,   0, 3, 2'b00, 1, "op timed");
    measure(LD,   2, 6, 2'b01, 6, "load timed waits2");
    measure(JALR, 1, 3, 2'b10, 2, "jalr timed waits1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
